// File: rtl/imem_if.sv
// imem_if: fetch (req/valid) and program-load ports of imem_sync
// slave  = memory side: drives ready, fetch_valid/data/err, prog_err
// master = fetch stage / loader side: drives fetch_req/addr, prog_we/addr/data
interface imem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              ready;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_err;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_err;
    modport slave (
        output ready, fetch_valid, fetch_data, fetch_err, prog_err,
        input  fetch_req, fetch_addr, prog_we, prog_addr, prog_data
    );
    modport master (
        input  ready, fetch_valid, fetch_data, fetch_err, prog_err,
        output fetch_req, fetch_addr, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/imem_sync.sv
// imem_sync: clocked instruction memory with registered fetch, program-load port and post-reset auto-clear
// clk, rst_n (async active-low); bus (imem_if.slave): ready, fetch req/addr -> valid/data/err, prog we/addr/data -> err
module imem_sync #(
    parameter int                ADDR_W = 8,
    parameter int                DATA_W = 16,
    parameter int                DEPTH  = 256,
    parameter logic [DATA_W-1:0] FILL   = DATA_W'(16'h1111)
) (
    input logic   clk,
    input logic   rst_n,
    imem_if.slave bus
);
    typedef enum logic {S_CLEAR, S_READY} state_t;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_clr_cnt, w_clr_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_fetch_data;
    logic              r_fetch_valid, r_fetch_err, r_prog_err;
    logic              w_ready, w_fetch_oob, w_prog_oob, w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    // extra top bit so DEPTH == 2**ADDR_W compares correctly
    assign w_fetch_oob = {1'b0, bus.fetch_addr} >= LIMIT;
    assign w_prog_oob  = {1'b0, bus.prog_addr} >= LIMIT;
    assign w_ready     = r_state == S_READY;
    // one write port shared by the clear engine and the program loader
    always_comb begin
        w_next     = r_state;
        w_clr_next = r_clr_cnt;
        w_we       = w_ready ? bus.prog_we && !w_prog_oob : 1'b1;
        w_waddr    = w_ready ? bus.prog_addr : r_clr_cnt;
        w_wdata    = w_ready ? bus.prog_data : FILL;
        if (r_state == S_CLEAR) begin
            w_clr_next = r_clr_cnt + 1'b1;
            w_next     = r_clr_cnt == ADDR_W'(DEPTH - 1) ? S_READY : S_CLEAR;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_CLEAR;
            r_clr_cnt     <= '0;
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= '0;
            r_fetch_err   <= 1'b0;
            r_prog_err    <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_clr_cnt     <= w_clr_next;
            r_fetch_valid <= w_ready && bus.fetch_req;
            r_prog_err    <= w_ready && bus.prog_we && w_prog_oob;
            if (w_ready && bus.fetch_req) begin
                r_fetch_data <= w_fetch_oob ? FILL : r_mem[bus.fetch_addr];
                r_fetch_err  <= w_fetch_oob;
            end
        end
    end
    // array kept reset-free; the fetch above reads the pre-write word on a same-cycle collision
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end
    assign bus.ready       = w_ready;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.fetch_data  = r_fetch_data;
    assign bus.fetch_err   = r_fetch_err;
    assign bus.prog_err    = r_prog_err;
endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: directed checks of imem_sync (default DEPTH=256 and a DEPTH=200 instance)
module tb_imem_sync;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_run = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    imem_if #(.ADDR_W(8), .DATA_W(16)) if_a ();
    imem_if #(.ADDR_W(8), .DATA_W(16)) if_b ();
    imem_sync #(.ADDR_W(8), .DATA_W(16), .DEPTH(256)) u_dut (.clk(clk), .rst_n(rst_n), .bus(if_a));
    imem_sync #(.ADDR_W(8), .DATA_W(16), .DEPTH(200)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if_b));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic fetch_a(input logic [7:0] a);
        if_a.fetch_req = 1'b1;
        if_a.fetch_addr = a;
        tick();
        if_a.fetch_req = 1'b0;
    endtask
    task automatic write_a(input logic [7:0] a, input logic [15:0] d);
        if_a.prog_we = 1'b1;
        if_a.prog_addr = a;
        if_a.prog_data = d;
        tick();
        if_a.prog_we = 1'b0;
    endtask
    task automatic wait_ready(input string tag);
        int n = 0;
        while (!if_a.ready && n < 400) begin
            tick();
            n++;
        end
        chk(tag, n, 256);
    endtask
    initial begin
        if_a.fetch_req = 0; if_a.fetch_addr = 0; if_a.prog_we = 0; if_a.prog_addr = 0; if_a.prog_data = 0;
        if_b.fetch_req = 0; if_b.fetch_addr = 0; if_b.prog_we = 0; if_b.prog_addr = 0; if_b.prog_data = 0;
        tick();
        tick();
        // T1 reset values and clear duration
        chk("rst_ready", if_a.ready, 0);
        chk("rst_fvalid", if_a.fetch_valid, 0);
        chk("rst_fdata", if_a.fetch_data, 0);
        chk("rst_ferr", if_a.fetch_err, 0);
        chk("rst_perr", if_a.prog_err, 0);
        rst_n = 1'b1;
        wait_ready("t1_clear_cycles");
        chk("t1_ready_b", if_b.ready, 1);
        if_a.fetch_req = 1'b1;
        if_a.fetch_addr = 8'h00;
        tick();
        chk("t1_v0", if_a.fetch_valid, 1);
        chk("t1_d0", if_a.fetch_data, 16'h1111);
        chk("t1_e0", if_a.fetch_err, 0);
        if_a.fetch_addr = 8'h7F;
        tick();
        chk("t1_d7f", if_a.fetch_data, 16'h1111);
        if_a.fetch_addr = 8'hFF;
        tick();
        chk("t1_vff", if_a.fetch_valid, 1);
        chk("t1_dff", if_a.fetch_data, 16'h1111);
        chk("t1_eff", if_a.fetch_err, 0);
        if_a.fetch_req = 1'b0;
        tick();
        chk("t1_idle_v", if_a.fetch_valid, 0);
        chk("t1_idle_hold", if_a.fetch_data, 16'h1111);
        // T2 load and back-to-back read
        write_a(8'd0, 16'b0000_000_001_010_000);
        chk("t2_perr0", if_a.prog_err, 0);
        write_a(8'd1, 16'b0001_010_011_001_000);
        if_a.fetch_req = 1'b1;
        if_a.fetch_addr = 8'd0;
        tick();
        chk("t2_d0", if_a.fetch_data, 16'h0050);
        if_a.fetch_addr = 8'd1;
        tick();
        chk("t2_v1", if_a.fetch_valid, 1);
        chk("t2_d1", if_a.fetch_data, 16'h14C8);
        if_a.fetch_req = 1'b0;
        tick();
        chk("t2_hold", if_a.fetch_data, 16'h14C8);
        // T3 same-cycle write and fetch returns old word
        write_a(8'd5, 16'hAAAA);
        if_a.prog_we = 1'b1;
        if_a.prog_addr = 8'd5;
        if_a.prog_data = 16'h5555;
        fetch_a(8'd5);
        if_a.prog_we = 1'b0;
        chk("t3_old", if_a.fetch_data, 16'hAAAA);
        fetch_a(8'd5);
        chk("t3_new", if_a.fetch_data, 16'h5555);
        // T4 DEPTH=200 bounds
        if_b.prog_we = 1'b1;
        if_b.prog_addr = 8'd200;
        if_b.prog_data = 16'hDEAD;
        tick();
        if_b.prog_we = 1'b0;
        chk("t4_perr_pulse", if_b.prog_err, 1);
        tick();
        chk("t4_perr_clr", if_b.prog_err, 0);
        if_b.fetch_req = 1'b1;
        if_b.fetch_addr = 8'd250;
        tick();
        chk("t4_v250", if_b.fetch_valid, 1);
        chk("t4_d250", if_b.fetch_data, 16'h1111);
        chk("t4_e250", if_b.fetch_err, 1);
        if_b.fetch_addr = 8'd199;
        tick();
        chk("t4_e199", if_b.fetch_err, 0);
        chk("t4_d199", if_b.fetch_data, 16'h1111);
        if_b.fetch_req = 1'b0;
        // T6 reset in READY: outputs clear at once, written words are cleared
        if_a.fetch_req = 1'b1;
        if_a.fetch_addr = 8'd5;
        tick();
        chk("t6_pre_v", if_a.fetch_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_v", if_a.fetch_valid, 0);
        chk("t6_async_d", if_a.fetch_data, 0);
        chk("t6_async_rdy", if_a.ready, 0);
        if_a.fetch_req = 1'b0;
        tick();
        rst_n = 1'b1;
        // T5 requests during CLEAR are ignored
        repeat (10) tick();
        if_a.fetch_req = 1'b1;
        if_a.fetch_addr = 8'd3;
        if_a.prog_we = 1'b1;
        if_a.prog_addr = 8'd3;
        if_a.prog_data = 16'hBEEF;
        tick();
        if_a.fetch_req = 1'b0;
        if_a.prog_we = 1'b0;
        chk("t5_v", if_a.fetch_valid, 0);
        chk("t5_perr", if_a.prog_err, 0);
        tick();
        chk("t5_perr2", if_a.prog_err, 0);
        // T6 reset mid-CLEAR restarts the full pass
        repeat (88) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_midclr_rdy", if_a.ready, 0);
        tick();
        rst_n = 1'b1;
        wait_ready("t6_clear_cycles");
        fetch_a(8'd3);
        chk("t5_addr3", if_a.fetch_data, 16'h1111);
        fetch_a(8'd5);
        chk("t6_addr5", if_a.fetch_data, 16'h1111);
        fetch_a(8'd0);
        chk("t6_addr0", if_a.fetch_data, 16'h1111);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
